pipe_scroller: RTL and testbench

//  Parametrised obstacle generator: scrolls NUM_PIPES pipes right-to-left at a level-selectable rate.

---
 rtl/flappy_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/pipe_scroller.sv | 147 ++++++++++++++
 tb/tb_pipe_scroller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the pipe obstacle generator: game state,
// gap-height table and the 8-bit gap-selection LFSR.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_e;

  // Taps for x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [9:0] HEIGHT_ROM [0:7] = '{
    10'd50, 10'd90, 10'd130, 10'd170, 10'd210, 10'd250, 10'd290, 10'd400
  };

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into 1-px movement steps; the divisor shrinks with Level.
// Counting only happens while en is high; dropping en clears the count.
module tick_prescaler #(
  parameter int TICK_DIV = 500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       en,
  input  logic [1:0] Level,
  output logic       step
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] count_q;
  logic [31:0]      div;
  logic [CNT_W-1:0] limit;

  // A divisor that shifts down to zero still steps every clock instead of never.
  always_comb begin
    div   = 32'(TICK_DIV) >> Level;
    limit = (div == 32'd0) ? '0 : CNT_W'(div - 32'd1);
    step  = en && (count_q >= limit);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else if (!en || step) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls NUM_PIPES obstacles right-to-left, staggering launches and
// respawning pipes that leave the screen with LFSR-chosen gap heights.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int         NUM_PIPES = 2,
  parameter int         X_W       = 10,
  parameter int         SCREEN_W  = 800,
  parameter int         SPACING   = 400,
  parameter int         BIRD_X    = 200,
  parameter int         TICK_DIV  = 500000,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Lost,
  input  logic [1:0]               Level,
  output logic [NUM_PIPES*X_W-1:0] PipePosX,
  output logic [NUM_PIPES*X_W-1:0] PipePosY,
  output logic [NUM_PIPES-1:0]     PipeActive,
  output logic                     Passed,
  output logic                     Running
);

  localparam logic [X_W-1:0] X_SPAWN  = X_W'(SCREEN_W);
  localparam logic [X_W-1:0] X_LAUNCH = X_W'(SCREEN_W - SPACING);
  localparam logic [X_W-1:0] X_BIRD   = X_W'(BIRD_X);
  localparam logic [X_W-1:0] Y_RESET  = X_W'(HEIGHT_ROM[0]);

  state_e               state_q;
  logic [X_W-1:0]       x_q [NUM_PIPES];
  logic [X_W-1:0]       y_q [NUM_PIPES];
  logic [NUM_PIPES-1:0] active_q;
  logic                 passed_q;
  logic                 running_q;
  logic [7:0]           lfsr_q;

  logic                 step;
  logic [X_W-1:0]       x_d [NUM_PIPES];
  logic [X_W-1:0]       y_d [NUM_PIPES];
  logic [NUM_PIPES-1:0] respawn_d;
  logic [NUM_PIPES-1:0] launch_d;
  logic [NUM_PIPES-1:0] hit_d;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .Clk  (Clk),
    .Reset(Reset),
    .en   (state_q == RUN),
    .Level(Level),
    .step (step)
  );

  // Per-pipe candidate values for the next step; the FSM decides whether to apply them.
  for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
    logic [2:0] rom_idx;

    assign rom_idx       = lfsr_q[2:0] + 3'(gi);
    assign y_d[gi]       = X_W'(HEIGHT_ROM[rom_idx]);
    assign x_d[gi]       = (x_q[gi] == '0) ? X_SPAWN : x_q[gi] - 1'b1;
    assign respawn_d[gi] = active_q[gi] && (x_q[gi] == '0);
    assign hit_d[gi]     = active_q[gi] && (x_d[gi] == X_BIRD);

    if (gi == 0) begin : g_first
      assign launch_d[gi] = 1'b0;
    end else begin : g_follow
      assign launch_d[gi] = !active_q[gi] && active_q[gi-1] && (x_d[gi-1] == X_LAUNCH);
    end

    assign PipePosX[gi*X_W +: X_W] = x_q[gi];
    assign PipePosY[gi*X_W +: X_W] = y_q[gi];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      active_q  <= '0;
      passed_q  <= 1'b0;
      running_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      for (int k = 0; k < NUM_PIPES; k++) begin
        x_q[k] <= X_SPAWN;
        y_q[k] <= Y_RESET;
      end
    end else begin
      passed_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            state_q     <= RUN;
            running_q   <= 1'b1;
            active_q[0] <= 1'b1;
            x_q[0]      <= X_SPAWN;
            y_q[0]      <= y_d[0];
            lfsr_q      <= lfsr_next(lfsr_q);
          end
        end
        RUN: begin
          // Lost wins over a coincident step so the final frame stays put.
          if (Lost) begin
            state_q   <= FROZEN;
            running_q <= 1'b0;
          end else if (step) begin
            for (int k = 0; k < NUM_PIPES; k++) begin
              if (active_q[k]) begin
                x_q[k] <= x_d[k];
                if (respawn_d[k]) begin
                  y_q[k] <= y_d[k];
                end
              end else if (launch_d[k]) begin
                active_q[k] <= 1'b1;
                x_q[k]      <= X_SPAWN;
                y_q[k]      <= y_d[k];
              end
            end
            if (|respawn_d || |launch_d) begin
              lfsr_q <= lfsr_next(lfsr_q);
            end
            passed_q <= |hit_d;
          end
        end
        FROZEN: begin
          // The LFSR keeps running across rounds so each game gets fresh gaps.
          if (Start) begin
            state_q  <= IDLE;
            active_q <= '0;
            for (int k = 0; k < NUM_PIPES; k++) begin
              x_q[k] <= X_SPAWN;
              y_q[k] <= Y_RESET;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign PipeActive = active_q;
  assign Passed     = passed_q;
  assign Running    = running_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller with a small screen and fast prescaler.
module tb_pipe_scroller;

  localparam int NP = 2;
  localparam int XW = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            lost = 1'b0;
  logic [1:0]      level = 2'd0;
  logic [NP*XW-1:0] pos_x;
  logic [NP*XW-1:0] pos_y;
  logic [NP-1:0]   active;
  logic            passed;
  logic            running;

  int checks = 0;
  int errors = 0;
  int pass_cnt = 0;

  pipe_scroller #(
    .NUM_PIPES(NP),
    .X_W      (XW),
    .SCREEN_W (40),
    .SPACING  (20),
    .BIRD_X   (10),
    .TICK_DIV (4),
    .LFSR_SEED(8'hA5)
  ) dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .Start     (start),
    .Lost      (lost),
    .Level     (level),
    .PipePosX  (pos_x),
    .PipePosY  (pos_y),
    .PipeActive(active),
    .Passed    (passed),
    .Running   (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         ncyc;
    logic [1:0] lvl;
    int         x0;
    int         x1;
    int         act;
    int         y0;
    int         y1;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end else begin
      $display("ok   %s: %0d", name, act_v);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; also tallies Passed pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (passed === 1'b1) begin
      pass_cnt++;
      if (pos_x[XW-1:0] != 10 && pos_x[2*XW-1:XW] != 10) begin
        checks++;
        errors++;
        $display("FAIL passed_pos: pulse with x0=%0d x1=%0d, required one at 10",
                 pos_x[XW-1:0], pos_x[2*XW-1:XW]);
      end
    end
  endtask

  task automatic check_state(input string tag, input int x0, input int x1, input int act,
                             input int y0, input int y1, input int run);
    chk({tag, ".x0"}, int'(pos_x[XW-1:0]), x0);
    chk({tag, ".x1"}, int'(pos_x[2*XW-1:XW]), x1);
    chk({tag, ".act"}, int'(active), act);
    if (y0 >= 0) chk({tag, ".y0"}, int'(pos_y[XW-1:0]), y0);
    if (y1 >= 0) chk({tag, ".y1"}, int'(pos_y[2*XW-1:XW]), y1);
    chk({tag, ".run"}, int'(running), run);
  endtask

  initial begin
    // Counts are cycles after the Start edge at Level 0 (one step per 4 clocks).
    vecs[0]  = '{"pre_step",  3, 2'd0, 40, 40, 1,  250, 50};
    vecs[1]  = '{"step1",     1, 2'd0, 39, 40, 1,  250, 50};
    vecs[2]  = '{"launch1",  76, 2'd0, 20, 40, 3,  250, 170};
    vecs[3]  = '{"step21",    4, 2'd0, 19, 39, 3,  250, 170};
    vecs[4]  = '{"step31",   40, 2'd0,  9, 29, 3,  250, 170};
    vecs[5]  = '{"x0_zero",  36, 2'd0,  0, 20, 3,  250, 170};
    vecs[6]  = '{"respawn",   4, 2'd0, 40, 19, 3,  250, 170};
    vecs[7]  = '{"step50",   36, 2'd0, 31, 10, 3,  250, 170};
    vecs[8]  = '{"lvl2_a",    1, 2'd2, 30,  9, 3,  250, 170};
    vecs[9]  = '{"lvl2_b",    1, 2'd2, 29,  8, 3,  250, 170};
    vecs[10] = '{"lvl0_hold", 2, 2'd0, 29,  8, 3,  250, 170};
    vecs[11] = '{"lvl3_a",    1, 2'd3, 28,  7, 3,  250, 170};
    vecs[12] = '{"lvl3_b",    1, 2'd3, 27,  6, 3,  250, 170};

    tick();
    tick();
    check_state("reset", 40, 40, 0, 50, 50, 0);
    chk("reset.passed", int'(passed), 0);
    rst_n = 1'b1;
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    check_state("start", 40, 40, 1, 250, 50, 1);

    for (int i = 0; i < 13; i++) begin
      level = vecs[i].lvl;
      for (int c = 0; c < vecs[i].ncyc; c++) tick();
      check_state(vecs[i].name, vecs[i].x0, vecs[i].x1, vecs[i].act,
                  vecs[i].y0, vecs[i].y1, 1);
      if (i == 4) chk("pass_cnt_31", pass_cnt, 1);
      if (i == 7) chk("pass_cnt_50", pass_cnt, 2);
    end

    // Lost coincides with a step (Level 3 steps every clock): nothing moves.
    lost = 1'b1;
    tick();
    lost = 1'b0;
    check_state("lost", 27, 6, 3, 250, 170, 0);
    chk("lost.passed", int'(passed), 0);
    tick();
    tick();
    tick();
    check_state("frozen", 27, 6, 3, 250, 170, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check_state("to_idle", 40, 40, 0, 50, 50, 0);
    tick();
    check_state("idle_hold", 40, 40, 0, 50, 50, 0);

    // LFSR carried over from the previous round selects a different gap.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_state("restart", 40, 40, 1, 130, 50, 1);

    start = 1'b1;
    lost = 1'b1;
    tick();
    chk("both_run.run", int'(running), 0);
    chk("both_run.act", int'(active), 1);
    tick();
    start = 1'b0;
    lost = 1'b0;
    check_state("both_frozen", 40, 40, 0, 50, 50, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check_state("round3", 40, 40, 1, 210, 50, 1);
    level = 2'd2;
    tick();
    tick();
    chk("round3.x0", int'(pos_x[XW-1:0]), 38);

    rst_n = 1'b0;
    tick();
    check_state("reset_run", 40, 40, 0, 50, 50, 0);
    chk("reset_run.passed", int'(passed), 0);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_state("after_reset", 40, 40, 1, 250, 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
